fifo_async_flags: RTL and testbench

Parametrised asynchronous clock-domain-crossing FIFO: the successor to the basic Gray-pointer async FIFO in the converter datapath. It adds a configurable synchroniser depth, registered almost-full and almost-empty flags, and a sticky overflow flag. A compile-time first-word-fall-through (FWFT) read port is also available. It sits between the host-side (write) and converter-side (read) clock domains on the audio sample and command paths.

---
 rtl/fifo_async_flags.sv | 150 +++++++++++++++
 tb/tb_fifo_async_flags.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_async_flags.sv
// fifo_async_flags: dual-clock FIFO with Gray-coded pointers crossing an
// S-stage synchroniser, registered occupancy counts on both sides,
// almost-full / almost-empty flags and a sticky overflow flag.
// Build option: define FIFO_ASYNC_FWFT_EN for a first-word-fall-through read
// port; left undefined, out_ready is a pop request and data follows one edge later.
module fifo_async_flags #(
    parameter int Nb = 8,
    parameter int M  = 2,
    parameter int S  = 2,
    parameter int AF = (1 << M) - 1,
    parameter int AE = 1
) (
    input  logic          in_clk,
    input  logic          out_clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [Nb-1:0] in_data,
    output logic          in_ready,
    output logic [M:0]    in_count,
    output logic          in_almost_full,
    output logic          in_overflow,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [Nb-1:0] out_data,
    output logic [M:0]    out_count,
    output logic          out_almost_empty
);
    localparam int         N         = 1 << M;
    // Full when the write pointer has lapped the read pointer: top two Gray bits differ.
    localparam logic [M:0] FULL_FLIP = (M + 1)'(3 << (M - 1));
    localparam logic [M:0] AF_T      = (M + 1)'(AF);
    localparam logic [M:0] AE_T      = (M + 1)'(AE);
    localparam logic       AF_RST    = (AF <= 0);

    function automatic logic [M:0] gray2bin(input logic [M:0] g);
        logic [M:0] b;
        b[M] = g[M];
        for (int i = M - 1; i >= 0; i--) b[i] = b[i + 1] ^ g[i];
        return b;
    endfunction

    logic [Nb-1:0] mem [N];

    logic [M:0] wr_bin, wr_gray, wr_bin_nxt, wr_gray_nxt, wr_cnt_nxt, rq_gray;
    logic [M:0] rd_bin, rd_gray, rd_bin_nxt, rd_gray_nxt, rd_cnt_nxt, wq_gray;
    logic [M:0] rd_sync [S];
    logic [M:0] wr_sync [S];
    logic       full, empty, wr_en, rd_en;

    assign in_ready = !full;
    assign wr_en    = in_valid && !full;
    assign rq_gray  = rd_sync[S-1];
    assign wq_gray  = wr_sync[S-1];

`ifdef FIFO_ASYNC_FWFT_EN
    // Refill the output register when it is empty or being consumed.
    assign rd_en = !empty && (!out_valid || out_ready);
`else
    assign rd_en = !empty && out_ready;
`endif

    // Storage write; contents are not reset because the pointers gate all reads.
    always_ff @(posedge in_clk) begin
        if (wr_en) mem[wr_bin[M-1:0]] <= in_data;
    end

    // Write-side next pointer and occupancy seen against the synced read pointer.
    always_comb begin
        wr_bin_nxt  = wr_bin + (M + 1)'(wr_en);
        wr_gray_nxt = wr_bin_nxt ^ (wr_bin_nxt >> 1);
        wr_cnt_nxt  = wr_bin_nxt - gray2bin(rq_gray);
    end

    // Read Gray pointer into the write domain.
    always_ff @(posedge in_clk) begin
        if (reset) begin
            for (int i = 0; i < S; i++) rd_sync[i] <= '0;
        end else begin
            rd_sync[0] <= rd_gray;
            for (int i = 1; i < S; i++) rd_sync[i] <= rd_sync[i-1];
        end
    end

    // Write pointer, full, count and flags.
    always_ff @(posedge in_clk) begin
        if (reset) begin
            wr_bin         <= '0;
            wr_gray        <= '0;
            full           <= 1'b0;
            in_count       <= '0;
            in_almost_full <= AF_RST;
            in_overflow    <= 1'b0;
        end else begin
            wr_bin         <= wr_bin_nxt;
            wr_gray        <= wr_gray_nxt;
            full           <= (wr_gray_nxt == (rq_gray ^ FULL_FLIP));
            in_count       <= wr_cnt_nxt;
            in_almost_full <= (wr_cnt_nxt >= AF_T);
            if (in_valid && full) in_overflow <= 1'b1;
        end
    end

    // Read-side next pointer and occupancy seen against the synced write pointer.
    always_comb begin
        rd_bin_nxt  = rd_bin + (M + 1)'(rd_en);
        rd_gray_nxt = rd_bin_nxt ^ (rd_bin_nxt >> 1);
        rd_cnt_nxt  = gray2bin(wq_gray) - rd_bin_nxt;
    end

    // Write Gray pointer into the read domain.
    always_ff @(posedge out_clk) begin
        if (reset) begin
            for (int i = 0; i < S; i++) wr_sync[i] <= '0;
        end else begin
            wr_sync[0] <= wr_gray;
            for (int i = 1; i < S; i++) wr_sync[i] <= wr_sync[i-1];
        end
    end

    // Read pointer, empty, count and flag.
    always_ff @(posedge out_clk) begin
        if (reset) begin
            rd_bin           <= '0;
            rd_gray          <= '0;
            empty            <= 1'b1;
            out_count        <= '0;
            out_almost_empty <= 1'b1;
        end else begin
            rd_bin           <= rd_bin_nxt;
            rd_gray          <= rd_gray_nxt;
            empty            <= (rd_gray_nxt == wq_gray);
            out_count        <= rd_cnt_nxt;
            out_almost_empty <= (rd_cnt_nxt <= AE_T);
        end
    end

    // Output register: load on a pop; a read request with nothing to load clears valid.
    always_ff @(posedge out_clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (rd_en) begin
            out_valid <= 1'b1;
            out_data  <= mem[rd_bin[M-1:0]];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_async_flags.sv
// tb_fifo_async_flags: directed bench for fifo_async_flags (legacy read port).
`timescale 1ns/100ps
module tb_fifo_async_flags;
    localparam int NB = 8, MB = 2, SB = 2, AFB = 3, AEB = 1;

    logic          in_clk = 1'b0, out_clk = 1'b0, reset = 1'b1;
    logic          in_valid = 1'b0, out_ready = 1'b0;
    logic [NB-1:0] in_data = '0;
    logic          in_ready, in_almost_full, in_overflow;
    logic          out_valid, out_almost_empty;
    logic [MB:0]   in_count, out_count;
    logic [NB-1:0] out_data;

    real in_half = 5.0, out_half = 13.5;
    int  total = 0, bad = 0;
    logic [7:0] got_q [$];

    always #(in_half)  in_clk  = ~in_clk;
    always #(out_half) out_clk = ~out_clk;

    fifo_async_flags #(.Nb(NB), .M(MB), .S(SB), .AF(AFB), .AE(AEB)) dut (
        .in_clk(in_clk), .out_clk(out_clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .in_count(in_count), .in_almost_full(in_almost_full), .in_overflow(in_overflow),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_count(out_count), .out_almost_empty(out_almost_empty)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge out_clk);
        reset = 1'b1;
        repeat (6) @(negedge out_clk);
        reset = 1'b0;
        repeat (3) @(negedge out_clk);
    endtask

    task automatic check_reset_vals(input string pfx);
        check_val({pfx, "_in_ready"}, 32'(in_ready), 1);
        check_val({pfx, "_out_valid"}, 32'(out_valid), 0);
        check_val({pfx, "_out_data"}, 32'(out_data), 0);
        check_val({pfx, "_in_count"}, 32'(in_count), 0);
        check_val({pfx, "_out_count"}, 32'(out_count), 0);
        check_val({pfx, "_almost_full"}, 32'(in_almost_full), 0);
        check_val({pfx, "_almost_empty"}, 32'(out_almost_empty), 1);
        check_val({pfx, "_overflow"}, 32'(in_overflow), 0);
    endtask

    task automatic wr_word(input logic [7:0] d);
        @(negedge in_clk);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge in_clk);
        in_valid = 1'b0;
    endtask

    // With out_ready held high, every edge either pops (valid=1) or clears valid.
    task automatic drain(input int cycles);
        got_q.delete();
        @(negedge out_clk);
        out_ready = 1'b1;
        repeat (cycles) begin
            @(negedge out_clk);
            if (out_valid) got_q.push_back(out_data);
        end
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] got_at(input int i);
        return (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD;
    endfunction

    task automatic run_stream(input real ih, input real oh, input string tag);
        int ri;
        ri = 0;
        in_half  = ih;
        out_half = oh;
        do_reset();
        fork
            begin
                int wi, cyc;
                wi = 0;
                cyc = 0;
                while (wi < 256 && cyc < 20000) begin
                    @(negedge in_clk);
                    cyc++;
                    if (in_valid) wi++;
                    in_valid = 1'b0;
                    if (wi < 256 && in_ready && $urandom_range(0, 3) != 0) begin
                        in_valid = 1'b1;
                        in_data  = wi[7:0];
                    end
                end
                in_valid = 1'b0;
            end
            begin
                int cyc;
                logic prev_rdy;
                cyc = 0;
                prev_rdy = 1'b0;
                while (ri < 256 && cyc < 20000) begin
                    @(negedge out_clk);
                    cyc++;
                    if (prev_rdy && out_valid) begin
                        check_val({tag, "_word"}, 32'(out_data), 32'(ri));
                        ri++;
                    end
                    out_ready = 1'($urandom_range(0, 1));
                    prev_rdy  = out_ready;
                end
                out_ready = 1'b0;
            end
        join
        repeat (10) @(negedge out_clk);
        check_val({tag, "_received"}, 32'(ri), 256);
        check_val({tag, "_overflow"}, 32'(in_overflow), 0);
        check_val({tag, "_out_count"}, 32'(out_count), 0);
        check_val({tag, "_in_count"}, 32'(in_count), 0);
    endtask

    initial begin
        logic [7:0] exp_a [4];
        logic [7:0] exp_c [4];
        int k;
        exp_a = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        exp_c = '{8'hC2, 8'hC3, 8'hC4, 8'hC5};

        // Reset values
        do_reset();
        check_reset_vals("rst");

        // Fill to full, then one write too many
        wr_word(8'hA1);
        wr_word(8'hA2);
        check_val("af_after2", 32'(in_almost_full), 0);
        wr_word(8'hA3);
        check_val("af_after3", 32'(in_almost_full), 1);
        check_val("cnt_after3", 32'(in_count), 3);
        check_val("rdy_after3", 32'(in_ready), 1);
        wr_word(8'hA4);
        check_val("rdy_after4", 32'(in_ready), 0);
        check_val("cnt_after4", 32'(in_count), 4);
        wr_word(8'hA5);
        check_val("ovf_after5", 32'(in_overflow), 1);
        check_val("cnt_after5", 32'(in_count), 4);
        repeat (8) @(negedge out_clk);
        check_val("out_cnt_full", 32'(out_count), 4);
        check_val("ae_full", 32'(out_almost_empty), 0);
        check_val("out_valid_idle", 32'(out_valid), 0);

        // Drain
        drain(12);
        check_val("drain_n", 32'(got_q.size()), 4);
        for (int i = 0; i < 4; i++) check_val("drain_word", got_at(i), 32'(exp_a[i]));
        check_val("drain_valid", 32'(out_valid), 0);
        check_val("drain_out_cnt", 32'(out_count), 0);
        check_val("drain_ae", 32'(out_almost_empty), 1);
        check_val("ovf_sticky", 32'(in_overflow), 1);
        repeat (8) @(negedge in_clk);
        check_val("drain_in_rdy", 32'(in_ready), 1);
        check_val("drain_in_cnt", 32'(in_count), 0);

        // Full with a write pending, single read pulse
        do_reset();
        wr_word(8'hC1);
        wr_word(8'hC2);
        wr_word(8'hC3);
        wr_word(8'hC4);
        @(negedge in_clk);
        in_valid = 1'b1;
        in_data  = 8'hC5;
        repeat (8) @(negedge out_clk);
        check_val("pulse_pre_rdy", 32'(in_ready), 0);
        @(negedge out_clk);
        out_ready = 1'b1;
        @(posedge out_clk);
        fork
            begin
                @(negedge out_clk);
                out_ready = 1'b0;
                check_val("pulse_valid", 32'(out_valid), 1);
                check_val("pulse_data", 32'(out_data), 32'hC1);
            end
            begin
                k = 0;
                while (k < 12) begin
                    @(posedge in_clk);
                    #1;
                    k++;
                    if (in_ready) break;
                end
                check_val("release_in_time", 32'(in_ready && (k <= SB + 3)), 1);
                @(posedge in_clk);
                #1;
                in_valid = 1'b0;
                check_val("refill_rdy", 32'(in_ready), 0);
                check_val("refill_cnt", 32'(in_count), 4);
            end
        join
        drain(12);
        check_val("pulse_drain_n", 32'(got_q.size()), 4);
        for (int i = 0; i < 4; i++) check_val("pulse_drain_word", got_at(i), 32'(exp_c[i]));

        // Reset with words stored
        do_reset();
        wr_word(8'hD1);
        wr_word(8'hD2);
        repeat (8) @(negedge out_clk);
        check_val("mid_out_cnt", 32'(out_count), 2);
        do_reset();
        check_reset_vals("mid");
        drain(12);
        check_val("mid_no_stale", 32'(got_q.size()), 0);
        wr_word(8'hE1);
        repeat (2) @(negedge out_clk);
        drain(12);
        check_val("mid_new_n", 32'(got_q.size()), 1);
        check_val("mid_new_word", got_at(0), 32'hE1);

        // Streaming in both clock ratios
        run_stream(5.0, 13.5, "fast_wr");
        run_stream(13.5, 5.0, "fast_rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
